// File: rtl/fetch_queue_if.sv
// fetch_queue bus bundle: icache request/fill and decode window.
// master = fetch queue side, slave = icache/decode side.
interface fetch_queue_if;
  logic         icache_en;
  logic [31:0]  icache_address;
  logic         icache_ready;
  logic [127:0] icache_data;
  logic         consume;
  logic [3:0]   instr_length;
  logic [127:0] IR_OUT;
  logic         window_valid;
  logic [31:0]  EIP_OUT;

  modport master (
    output icache_en,
    output icache_address,
    input  icache_ready,
    input  icache_data,
    input  consume,
    input  instr_length,
    output IR_OUT,
    output window_valid,
    output EIP_OUT
  );

  modport slave (
    input  icache_en,
    input  icache_address,
    output icache_ready,
    output icache_data,
    output consume,
    output instr_length,
    input  IR_OUT,
    input  window_valid,
    input  EIP_OUT
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH x 16-byte line ring feeding a byte window.
// Optional code-segment limit check enabled by FETCH_SEGLIMIT_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH) + 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_eip,
  input  logic [31:0] new_eip,
  input  logic [31:0] cs_limit,
  output logic        segment_limit_exception,
  fetch_queue_if.master bus
);

  localparam int LW = $clog2(DEPTH);
  localparam logic [LW:0]   FULL   = (LW+1)'(DEPTH);
  localparam logic [LW:0]   U_ONE  = 1;
  localparam logic [LW-1:0] WP_ONE = 1;

  logic [31:0]      fa_q, fa_d;
  logic [31:0]      eip_q, eip_d;
  logic [LW-1:0]    wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [LW:0]      used_q, used_d;
  logic             pend_q, pend_d;
  logic             skip_q, skip_d;
  logic             exc_q, exc_d;
  logic             run_q;
  logic [127:0]     line_q [DEPTH];

  logic [LW-1:0]    head, nxt;
  logic [255:0]     pair;
  logic [255:0]     win;
  logic [PTR_W:0]   avail;
  logic             w_valid;
  logic             blocked;
  logic             can_req;
  logic             en;
  logic             fill;
  logic             take;
  logic             free;
  logic [4:0]       sum;

  assign head  = rp_q[PTR_W-1:4];
  assign nxt   = head + WP_ONE;
  assign pair  = {line_q[nxt], line_q[head]};
  assign win   = pair >> {rp_q[3:0], 3'b000};

  assign avail = {used_q, 4'h0}
               - {{(PTR_W-3){1'b0}}, rp_q[3:0]};
  assign w_valid = (used_q != '0)
                && (avail[PTR_W:4] != '0);

`ifdef FETCH_SEGLIMIT_EN
  assign blocked = fa_q > cs_limit;
`else
  logic unused_cs;
  assign unused_cs = ^cs_limit;
  assign blocked   = 1'b0;
`endif

  assign can_req = (used_q != FULL) && !blocked;
  // once issued, a request stays up until its ready strobe
  assign en   = run_q && !load_eip
             && (pend_q || can_req);
  assign fill = bus.icache_ready && en && !skip_q;
  assign take = bus.consume && w_valid
             && (bus.instr_length != 4'h0);
  assign sum  = {1'b0, rp_q[3:0]}
              + {1'b0, bus.instr_length};
  assign free = take && sum[4];

  assign bus.icache_en      = en;
  assign bus.icache_address = fa_q;
  assign bus.IR_OUT         = win[127:0];
  assign bus.window_valid   = w_valid;
  assign bus.EIP_OUT        = eip_q;
  assign segment_limit_exception = exc_q;

  always_comb begin
    fa_d   = fa_q;
    eip_d  = eip_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    used_d = used_q;
    pend_d = pend_q;
    skip_d = skip_q;
    exc_d  = exc_q;
    if (load_eip) begin
      fa_d   = {new_eip[31:4], 4'h0};
      eip_d  = new_eip;
      wp_d   = '0;
      rp_d   = PTR_W'(new_eip[3:0]);
      used_d = '0;
      pend_d = 1'b0;
      // late response of an abandoned request must not land
      skip_d = pend_q && !bus.icache_ready;
      exc_d  = 1'b0;
    end else begin
      if (fill) begin
        fa_d = fa_q + 32'd16;
        wp_d = wp_q + WP_ONE;
      end
      if (take) begin
        rp_d  = rp_q + PTR_W'(bus.instr_length);
        eip_d = eip_q + 32'(bus.instr_length);
      end
      if (fill && !free) begin
        used_d = used_q + U_ONE;
      end else if (!fill && free) begin
        used_d = used_q - U_ONE;
      end
      pend_d = en && !fill;
      if (en) begin
        skip_d = 1'b0;
      end
`ifdef FETCH_SEGLIMIT_EN
      if (blocked && !pend_q && !w_valid) begin
        exc_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fa_q   <= '0;
      eip_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      used_q <= '0;
      pend_q <= 1'b0;
      skip_q <= 1'b0;
      exc_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      fa_q   <= fa_d;
      eip_q  <= eip_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      used_q <= used_d;
      pend_q <= pend_d;
      skip_q <= skip_d;
      exc_q  <= exc_d;
      run_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else if (fill) begin
      line_q[wp_q] <= bus.icache_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: byte-stream model plus directed scenarios.
// A simple icache responder returns lines after a fixed latency.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_eip;
  logic [31:0] new_eip;
  logic [31:0] cs_limit;
  logic        seg_exc;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .load_eip                (load_eip),
    .new_eip                 (new_eip),
    .cs_limit                (cs_limit),
    .segment_limit_exception (seg_exc),
    .bus                     (bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nfill = 0;
  logic [31:0] reqlog[$];

  logic [31:0] m_eip, m_fa;
  bit          m_pend, m_run, m_exc;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [127:0] mwin(input logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = mb(a + i);
    return r;
  endfunction

  // Model view: bytes fetched are [line(eip), fa); lines held = that span / 16
  function automatic logic [31:0] f_lines();
    logic [31:0] d;
    d = m_fa - {m_eip[31:4], 4'h0};
    return d >> 4;
  endfunction

  function automatic bit f_ok();
`ifdef FETCH_SEGLIMIT_EN
    return m_fa <= cs_limit;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit f_valid();
    return $signed(m_fa - m_eip) >= 16;
  endfunction

  function automatic bit f_en();
    return m_run && !load_eip
        && (m_pend || (f_lines() < DEPTH && f_ok()));
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_eip = 0; m_fa = 0; m_pend = 0; m_exc = 0; m_run = 0;
      end else begin
        bit e, v, acc, cond;
        e = f_en();
        v = f_valid();
        cond = !m_pend && !f_ok() && !v;
        m_run = 1;
        if (load_eip) begin
          m_fa = {new_eip[31:4], 4'h0};
          m_eip = new_eip;
          m_pend = 0;
          m_exc = 0;
        end else begin
          acc = bus.icache_ready && e;
          if (acc) m_fa = m_fa + 32'd16;
          m_pend = e && !acc;
          if (bus.consume && v && bus.instr_length != 0)
            m_eip = m_eip + 32'(bus.instr_length);
`ifdef FETCH_SEGLIMIT_EN
          if (cond) m_exc = 1;
`endif
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.icache_ready && bus.icache_en) nfill++;
      chk("en", 128'(bus.icache_en), 128'(f_en()));
      if (f_en())
        chk("addr", 128'(bus.icache_address), 128'(m_fa));
      chk("valid", 128'(bus.window_valid), 128'(f_valid()));
      chk("eip", 128'(bus.EIP_OUT), 128'(m_eip));
      if (f_valid())
        chk("ir", bus.IR_OUT, mwin(m_eip));
      else if (!m_run)
        chk("ir_rst", bus.IR_OUT, 128'h0);
`ifdef FETCH_SEGLIMIT_EN
      chk("exc", 128'(seg_exc), 128'(m_exc));
`endif
    end
  end

  bit          busy = 0;
  int          cnt = 0;
  logic [31:0] raddr;

  initial begin
    bus.icache_ready = 0;
    bus.icache_data = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.icache_ready = 0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.icache_ready = 1;
          bus.icache_data = mwin(raddr);
          busy = 0;
        end
      end
      if (load_eip && !bus.icache_ready) busy = 0;
      if (!busy && !bus.icache_ready && bus.icache_en) begin
        busy = 1;
        cnt = LAT;
        raddr = bus.icache_address;
        reqlog.push_back(raddr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    load_eip = 0;
    bus.consume = 0;
    bus.instr_length = 0;
  endtask

  task automatic redirect(input logic [31:0] a);
    step();
    load_eip = 1;
    new_eip = a;
    nfill = 0;
    reqlog.delete();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    step();
    while (!bus.window_valid && k < 60) begin
      step();
      k++;
    end
    tests++;
    if (!bus.window_valid) begin
      fails++;
      $display("FAIL %s: window_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic do_consume(input int len);
    wait_valid("consume_wait");
    bus.consume = 1;
    bus.instr_length = 4'(len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    load_eip = 0;
    new_eip = 0;
    cs_limit = 32'hFFFF_FFFF;
    bus.consume = 0;
    bus.instr_length = 0;
    repeat (3) step();
    chk("rst_en", 128'(bus.icache_en), 128'h0);
    chk("rst_valid", 128'(bus.window_valid), 128'h0);
    chk("rst_ir", bus.IR_OUT, 128'h0);
    chk("rst_eip", 128'(bus.EIP_OUT), 128'h0);
    chk("rst_exc", 128'(seg_exc), 128'h0);

    step();
    reset = 1;
    load_eip = 1;
    new_eip = 32'h100;
    nfill = 0;
    reqlog.delete();
    wait_valid("first_fill");
    chk("first_nfill", 128'(nfill), 128'd1);
    chk("first_eip", 128'(bus.EIP_OUT), 128'h100);
    chk("first_b0", 128'(bus.IR_OUT[7:0]), 128'h5B);
    chk("first_b15", 128'(bus.IR_OUT[127:120]), 128'h54);

    repeat (30) step();
    chk("req0", 128'(reqlog[0]), 128'h100);
    chk("req1", 128'(reqlog[1]), 128'h110);
    chk("full_nfill", 128'(nfill), 128'd4);
    chk("full_nreq", 128'(reqlog.size()), 128'd4);
    chk("full_en", 128'(bus.icache_en), 128'h0);

    do_consume(9);
    do_consume(7);
    repeat (20) step();
    chk("free_nfill", 128'(nfill), 128'd5);
    chk("free_en", 128'(bus.icache_en), 128'h0);
    chk("free_eip", 128'(bus.EIP_OUT), 128'h110);

    repeat (5) do_consume(15);
    step();
    chk("wrap_eip", 128'(bus.EIP_OUT), 128'h15B);
    chk("wrap_b0", 128'(bus.IR_OUT[7:0]), 128'h00);

    redirect(32'h10B);
    wait_valid("unaligned");
    chk("ua_nfill", 128'(nfill), 128'd2);
    chk("ua_eip", 128'(bus.EIP_OUT), 128'h10B);
    chk("ua_b0", 128'(bus.IR_OUT[7:0]), 128'h50);
    chk("ua_b15", 128'(bus.IR_OUT[127:120]), 128'h41);

    redirect(32'h300);
    begin
      int k = 0;
      bit hit = 0;
      while (!hit && k < 20) begin
        step();
        #2;
        if (bus.icache_ready) begin
          load_eip = 1;
          new_eip = 32'h200;
          nfill = 0;
          hit = 1;
        end
        k++;
      end
      chk("same_hit", 128'(hit), 128'h1);
    end
    step();
    #2;
    chk("same_en", 128'(bus.icache_en), 128'h1);
    chk("same_addr", 128'(bus.icache_address), 128'h200);
    chk("same_valid", 128'(bus.window_valid), 128'h0);
    wait_valid("same_cycle");
    chk("same_nfill", 128'(nfill), 128'd1);
    chk("same_eip", 128'(bus.EIP_OUT), 128'h200);
    chk("same_b0", 128'(bus.IR_OUT[7:0]), 128'h58);

`ifdef FETCH_SEGLIMIT_EN
    cs_limit = 32'h12F;
    redirect(32'h120);
    wait_valid("seg_fill");
    bus.consume = 1;
    bus.instr_length = 4'd10;
    repeat (6) step();
    chk("seg_exc", 128'(seg_exc), 128'h1);
    chk("seg_nfill", 128'(nfill), 128'd1);
    chk("seg_en", 128'(bus.icache_en), 128'h0);
    chk("seg_eip", 128'(bus.EIP_OUT), 128'h12A);
    cs_limit = 32'hFFFF_FFFF;
    redirect(32'h100);
    step();
    chk("seg_clr", 128'(seg_exc), 128'h0);
`endif

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
